// File: rtl/and_result_serializer.sv
// and_result_serializer: takes one AND-stage result word over a
// valid/ready handshake and shifts it out MSB first, counting the ones.
//
// Ports:
//   clk, rst_n  clock (rising edge); asynchronous active-low reset
//   in_valid    input word is valid
//   in_ready    block can accept a word (IDLE only)
//   in_data     WIDTH-bit word to serialise
//   ser_out     current serial bit, the shift register MSB
//   ser_valid   ser_out is valid (SHIFT only)
//   ser_ready   consumer takes ser_out on this edge
//   done        one-cycle pulse after the last bit is taken
//   ones_count  set bits sent from the current or most recent word
//   busy        high in SHIFT or DONE
module and_result_serializer #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int BW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done,
  output logic [CW-1:0]    ones_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    ones_q, ones_d;

  logic msb;
  logic beat;

  assign msb  = shreg_q[WIDTH-1];
  // A beat is taken only while SHIFT presents a bit.
  assign beat = (state_q == SHIFT) && ser_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          ones_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          ones_d  = ones_q + CW'(msb);
          cnt_d   = cnt_q + BW'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so no input reaches them
  // combinationally. After a full word the shift register is all
  // zeros, which keeps ser_out low outside SHIFT.
  assign in_ready   = (state_q == IDLE);
  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = msb;
  assign done       = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign ones_count = ones_q;

endmodule

// File: tb/tb_and_result_serializer.sv
// Bench for and_result_serializer: expected serial bits are queued when
// a word is offered and popped as the DUT presents each accepted beat.
module tb_and_result_serializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_ready = 1'b0;
  logic          done;
  logic [CW-1:0] ones_count;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];

  and_result_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .done       (done),
    .ones_count (ones_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
  endtask

  // Offer a word from IDLE at a negedge; optionally keep in_valid high
  // with a different word afterwards.
  task automatic load_word(input logic [W-1:0] w, input bit hold,
                           input logic [W-1:0] other, input string tag);
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s load: in_ready=%b busy=%b need 1/0",
               tag, in_ready, busy);
    end
    in_data  = w;
    in_valid = 1'b1;
    push_word(w);
    @(negedge clk);
    if (hold) in_data = other;
    else in_valid = 1'b0;
  endtask

  // Consume the word beat by beat, optionally stalling stall_len
  // cycles once stall_at bits have been taken.
  task automatic drain_word(input int stall_at, input int stall_len,
                            input logic [CW-1:0] exp_ones,
                            input string tag);
    int acc = 0;
    int cyc = 0;
    int stalled = 0;
    bit b;
    while (acc < W && cyc < 4 * W + 16) begin
      vectors++;
      if (ser_valid !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 ||
          ser_out !== exp_q[0]) begin
        miscompares++;
        $display("FAIL %s bit%0d: ser_out=%b valid=%b done=%b rdy=%b need %b/1/0/0",
                 tag, acc, ser_out, ser_valid, done, in_ready, exp_q[0]);
      end
      if (acc == stall_at && stalled < stall_len) begin
        ser_ready = 1'b0;
        stalled++;
      end else begin
        ser_ready = 1'b1;
        b = exp_q.pop_front();
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    ser_ready = 1'b0;
    vectors++;
    if (acc != W) begin
      miscompares++;
      $display("FAIL %s timeout: accepted %0d need %0d", tag, acc, W);
    end
    vectors++;
    if (done !== 1'b1 || ser_valid !== 1'b0 || in_ready !== 1'b0 ||
        busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_cycle: done=%b valid=%b rdy=%b busy=%b need 1/0/0/1",
               tag, done, ser_valid, in_ready, busy);
    end
    vectors++;
    if (ones_count !== exp_ones) begin
      miscompares++;
      $display("FAIL %s ones: got %0d need %0d", tag, ones_count, exp_ones);
    end
    vectors++;
    if (cyc != W + stall_len) begin
      miscompares++;
      $display("FAIL %s latency: got %0d need %0d", tag, cyc, W + stall_len);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        ser_valid !== 1'b0 || ones_count !== exp_ones) begin
      miscompares++;
      $display("FAIL %s idle: done=%b rdy=%b busy=%b valid=%b ones=%0d need 0/1/0/0/%0d",
               tag, done, in_ready, busy, ser_valid, ones_count, exp_ones);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || ser_valid !== 1'b0 || done !== 1'b0 ||
        ones_count !== '0 || busy !== 1'b0 || ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b valid=%b done=%b ones=%0d busy=%b out=%b need 1/0/0/0/0/0",
               in_ready, ser_valid, done, ones_count, busy, ser_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_word(8'hA5, 1'b0, '0, "a5");
    drain_word(0, 0, 4'd4, "a5");
  endtask

  task automatic test_backpressure();
    load_word(8'hC3, 1'b0, '0, "c3");
    drain_word(1, 3, 4'd4, "c3");
  endtask

  task automatic test_extremes();
    load_word(8'hFF, 1'b0, '0, "ff");
    drain_word(0, 0, 4'd8, "ff");
    load_word(8'h00, 1'b0, '0, "00");
    drain_word(0, 0, 4'd0, "00");
    load_word(8'h5A, 1'b0, '0, "5a");
    drain_word(5, 2, 4'd4, "5a");
  endtask

  task automatic test_ignore_in();
    load_word(8'hF0, 1'b1, 8'h0F, "f0");
    drain_word(0, 0, 4'd4, "f0");
    // in_valid stayed high with 0x0F; it loads now from IDLE.
    push_word(8'h0F);
    @(negedge clk);
    in_valid = 1'b0;
    drain_word(0, 0, 4'd4, "0f");
  endtask

  task automatic test_mid_reset();
    bit b;
    load_word(8'hFF, 1'b0, '0, "rst");
    ser_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = exp_q.pop_front();
      @(negedge clk);
    end
    vectors++;
    if (ones_count !== 4'd3 || ser_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_ones: ones=%0d valid=%b need 3/1", ones_count, ser_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    ser_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || ser_valid !== 1'b0 || done !== 1'b0 ||
        ones_count !== '0 || busy !== 1'b0 || ser_out !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: rdy=%b valid=%b done=%b ones=%0d busy=%b out=%b need 1/0/0/0/0/0",
               in_ready, ser_valid, done, ones_count, busy, ser_out);
    end
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_hold%0d: done=%b busy=%b need 0/0", i, done, busy);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    load_word(8'h81, 1'b0, '0, "81");
    drain_word(0, 0, 4'd2, "81");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_extremes();
    test_ignore_in();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
